uart_axil_master: RTL and testbench



---
 rtl/uart_axil_master.sv | 189 ++++++++++++++++++
 tb/tb_uart_axil_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_axil_master.sv
// uart_axil_master
// Turns single register commands (read or write, one at a time) into
// AXI4-Lite master transactions and returns one response per command.
//
// Ports
//   aclk, areset             clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_we                   1 = write, 0 = read
//   cmd_addr                 register byte address
//   cmd_wdata, cmd_wstrb     write data and byte strobes
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata                read data (0 for writes and aborts)
//   rsp_resp                 AXI response code (2'b10 on abort)
//   rsp_timeout              1 when the transaction was aborted by the wait counter
//   M_AXI_*                  AXI4-Lite master channels AW, W, B, AR, R
//   dbg_state                current FSM state
//
// Handshake rule on every channel (cmd, rsp and all AXI channels): a transfer
// happens at a rising edge where VALID and READY are both high; once VALID
// is raised it stays high, with its payload unchanged, until that transfer.
// The only exceptions are reset and the wait-counter abort, which withdraw
// every AXI VALID/READY this block drives.
module uart_axil_master #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 5,
   parameter int TIMEOUT_CYCLES     = 256
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_we,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [31:0]                     cmd_wdata,
   input  logic [3:0]                      cmd_wstrb,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [31:0]                     rsp_rdata,
   output logic [1:0]                      rsp_resp,
   output logic                            rsp_timeout,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY,
   output logic [2:0]                      dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_WRESP = 3'd2,
      S_READ  = 3'd3,
      S_RDATA = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   // The counter reads k-1 in the k-th wait cycle, so matching TIMEOUT-1
   // aborts after exactly TIMEOUT_CYCLES cycles without a completion.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t                          state, state_nxt;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
   logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
   logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
   logic [15:0]                     wait_cnt;
   logic                            aw_done, w_done;
   logic                            aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic                            waiting, progress, timeout_hit, abort;

   // ---------------- state register ----------------
   always_ff @(posedge aclk) begin
      if (areset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Channel handshakes and the abort decision. A completing handshake in
   // the same cycle as the timeout takes priority over the abort.
   always_comb begin
      aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
      w_hs        = M_AXI_WVALID  && M_AXI_WREADY;
      b_hs        = M_AXI_BVALID  && M_AXI_BREADY;
      ar_hs       = M_AXI_ARVALID && M_AXI_ARREADY;
      r_hs        = M_AXI_RVALID  && M_AXI_RREADY;
      timeout_hit = (wait_cnt == TO_LAST);
      waiting     = (state == S_WRITE) || (state == S_WRESP) ||
                    (state == S_READ)  || (state == S_RDATA);
      progress    = 1'b0;
      case (state)
         S_WRITE: progress = (aw_done || aw_hs) && (w_done || w_hs);
         S_WRESP: progress = b_hs;
         S_READ:  progress = ar_hs;
         S_RDATA: progress = r_hs;
         default: progress = 1'b0;
      endcase
      abort = waiting && !progress && timeout_hit;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (cmd_valid) state_nxt = cmd_we ? S_WRITE : S_READ;
         S_WRITE: if (progress) state_nxt = S_WRESP;
                  else if (abort) state_nxt = S_RESP;
         S_WRESP: if (progress || abort) state_nxt = S_RESP;
         S_READ:  if (progress) state_nxt = S_RDATA;
                  else if (abort) state_nxt = S_RESP;
         S_RDATA: if (progress || abort) state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   // AW and W each drop on their own handshake; the state stays WRITE until
   // both have completed. cmd_ready is held low while reset is asserted.
   always_comb begin
      cmd_ready     = (state == S_IDLE) && !areset;
      M_AXI_AWVALID = (state == S_WRITE) && !aw_done;
      M_AXI_WVALID  = (state == S_WRITE) && !w_done;
      M_AXI_BREADY  = (state == S_WRESP);
      M_AXI_ARVALID = (state == S_READ);
      M_AXI_RREADY  = (state == S_RDATA);
      rsp_valid     = (state == S_RESP);
      M_AXI_AWADDR  = addr_q;
      M_AXI_ARADDR  = addr_q;
      M_AXI_WDATA   = wdata_q;
      M_AXI_WSTRB   = wstrb_q;
      M_AXI_AWPROT  = 3'b000;
      M_AXI_ARPROT  = 3'b000;
      dbg_state     = state;
   end

   // ---------------- datapath ----------------
   always_ff @(posedge aclk) begin
      if (areset) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         wait_cnt    <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         rsp_rdata   <= '0;
         rsp_resp    <= 2'b00;
         rsp_timeout <= 1'b0;
      end else begin
         if (state == S_IDLE && cmd_valid) begin
            addr_q   <= cmd_addr;
            wdata_q  <= cmd_wdata;
            wstrb_q  <= cmd_wstrb;
            wait_cnt <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
         end
         if (waiting) wait_cnt <= wait_cnt + 16'd1;
         if (aw_hs)   aw_done  <= 1'b1;
         if (w_hs)    w_done   <= 1'b1;
         if (abort) begin
            rsp_rdata   <= '0;
            rsp_resp    <= 2'b10;
            rsp_timeout <= 1'b1;
         end else if (state == S_WRESP && b_hs) begin
            rsp_rdata   <= '0;
            rsp_resp    <= M_AXI_BRESP;
            rsp_timeout <= 1'b0;
         end else if (state == S_RDATA && r_hs) begin
            rsp_rdata   <= M_AXI_RDATA;
            rsp_resp    <= M_AXI_RRESP;
            rsp_timeout <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_axil_master.sv
// tb_uart_axil_master
// Drives commands into uart_axil_master with an 8-word AXI4-Lite slave
// modelled in the bench. Expected behaviour comes from a cycle timeline
// derived from channel delays (when each VALID/READY should be high, when
// the response appears, whether the wait counter aborts) plus a reference
// register array updated with mask arithmetic.
module tb_uart_axil_master;
   localparam int TO    = 8;   // TIMEOUT_CYCLES given to the DUT
   localparam int NEVER = 99;  // delay that never elapses inside a transaction

   // ---------------- clock / reset ----------------
   logic aclk = 1'b0;
   logic areset = 1'b1;
   always #5 aclk = ~aclk;

   logic        cmd_valid = 1'b0, cmd_we = 1'b0;
   logic        cmd_ready;
   logic [4:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid, rsp_timeout;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [4:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot, dbg_state;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [31:0] wdata, rdata = '0;
   logic [3:0]  wstrb;
   logic [1:0]  bresp = '0, rresp = '0;

   uart_axil_master #(
      .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(5), .TIMEOUT_CYCLES(TO)
   ) dut (
      .aclk(aclk), .areset(areset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
      .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
      .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid),
      .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
      .M_AXI_RREADY(rready),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [31:0] mem_slv [8];   // storage behind the bench's slave
   logic [31:0] mem_ref [8];   // reference register contents
   int n_vec = 0;
   int n_mis = 0;

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic slave_idle();
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
   endtask

   task automatic junk_cmd();
      cmd_valid = 1'b1;
      cmd_we    = 1'($urandom);
      cmd_addr  = 5'($urandom);
      cmd_wdata = $urandom;
      cmd_wstrb = 4'($urandom);
   endtask

   // One command from presentation to response handshake. Caller is at a
   // falling edge. rst_k > 0 pulses reset in that cycle after acceptance.
   task automatic run_txn(input bit we, input logic [4:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int aw_d, input int w_d, input int b_d,
                          input int ar_d, input int r_d, input logic [1:0] rc,
                          input int hold, input int rst_k);
      int aw_k, w_k, wr_k, ar_k, done_k, end_k, rsp_k;
      int s_aw_k, s_w_k, s_ar_k;
      bit s_b_done, s_r_done, exp_to;
      logic [4:0]  s_awaddr, s_araddr;
      logic [31:0] s_wdata, exp_rdata, mask;
      logic [3:0]  s_wstrb;
      logic [1:0]  exp_resp;
      int idx;
      // model timeline, cycles counted from acceptance
      aw_k = 1 + aw_d; w_k = 1 + w_d; wr_k = max2(aw_k, w_k); ar_k = 1 + ar_d;
      done_k = we ? (wr_k + 1 + b_d) : (ar_k + 1 + r_d);
      exp_to = (done_k > TO);
      end_k  = exp_to ? TO : done_k;
      rsp_k  = end_k + 1;
      idx = int'(addr) / 4;
      exp_rdata = (exp_to || we) ? 32'h0 : mem_ref[idx];
      exp_resp  = exp_to ? 2'b10 : rc;
      if (we && wr_k <= end_k && (rst_k == 0 || wr_k < rst_k)) begin
         mask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
         mem_ref[idx] = (mem_ref[idx] & ~mask) | (wd & mask);
      end
      s_aw_k = 0; s_w_k = 0; s_ar_k = 0; s_b_done = 0; s_r_done = 0;
      s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;

      cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      @(negedge aclk);
      for (int k = 1; k <= rsp_k; k++) begin
         if (rst_k == k) begin
            areset = 1'b1; cmd_valid = 1'b0; slave_idle();
            @(negedge aclk);
            chk("rst_bready", 32'(bready), 32'd0);
            chk("rst_awvalid", 32'(awvalid), 32'd0);
            chk("rst_wvalid", 32'(wvalid), 32'd0);
            chk("rst_arvalid", 32'(arvalid), 32'd0);
            chk("rst_rready", 32'(rready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_rsp_resp", 32'(rsp_resp), 32'd0);
            chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
            areset = 1'b0;
            @(negedge aclk);
            chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
            chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            return;
         end
         chk("awvalid", 32'(awvalid), 32'(we && k <= min2(aw_k, end_k)));
         chk("wvalid", 32'(wvalid), 32'(we && k <= min2(w_k, end_k)));
         chk("bready", 32'(bready), 32'(we && k >= wr_k + 1 && k <= end_k));
         chk("arvalid", 32'(arvalid), 32'(!we && k <= min2(ar_k, end_k)));
         chk("rready", 32'(rready), 32'(!we && k >= ar_k + 1 && k <= end_k));
         chk("rsp_valid", 32'(rsp_valid), 32'(k == rsp_k));
         chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
         if (awvalid) chk("awaddr", 32'(awaddr), 32'(addr));
         if (wvalid) begin
            chk("wdata", wdata, wd);
            chk("wstrb", 32'(wstrb), 32'(ws));
         end
         if (arvalid) chk("araddr", 32'(araddr), 32'(addr));
         if (k == 1) begin
            chk("awprot", 32'(awprot), 32'd0);
            chk("arprot", 32'(arprot), 32'd0);
         end
         if (k < rsp_k) begin
            // slave: ready after its delay, responses after both requests land
            awready = (k >= 1 + aw_d);
            wready  = (k >= 1 + w_d);
            arready = (k >= 1 + ar_d);
            bvalid  = !s_b_done && s_aw_k > 0 && s_w_k > 0 &&
                      k >= max2(s_aw_k, s_w_k) + 1 + b_d;
            bresp   = rc;
            rvalid  = !s_r_done && s_ar_k > 0 && k >= s_ar_k + 1 + r_d;
            rdata   = rvalid ? mem_slv[s_araddr[4:2]] : 32'h0;
            rresp   = rc;
            if (awvalid && awready && s_aw_k == 0) begin s_aw_k = k; s_awaddr = awaddr; end
            if (wvalid && wready && s_w_k == 0) begin s_w_k = k; s_wdata = wdata; s_wstrb = wstrb; end
            if (arvalid && arready && s_ar_k == 0) begin s_ar_k = k; s_araddr = araddr; end
            if (bvalid && bready) s_b_done = 1;
            if (rvalid && rready) s_r_done = 1;
            if (s_aw_k == k && s_w_k > 0 || s_w_k == k && s_aw_k > 0 && s_aw_k != k)
               for (int b = 0; b < 4; b++)
                  if (s_wstrb[b]) mem_slv[s_awaddr[4:2]][8*b +: 8] = s_wdata[8*b +: 8];
            junk_cmd();
            @(negedge aclk);
         end
      end
      slave_idle();
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
      for (int h = 0; h < hold; h++) begin
         rsp_ready = 1'b0;
         junk_cmd();
         @(negedge aclk);
         chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("hold_rsp_rdata", rsp_rdata, exp_rdata);
         chk("hold_rsp_resp", 32'(rsp_resp), 32'(exp_resp));
         chk("hold_rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
         chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      junk_cmd();
      @(negedge aclk);
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("done_cmd_ready", 32'(cmd_ready), 32'd1);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int a, aw_d, w_d, b_d, ar_d, r_d;
      for (int i = 0; i < 8; i++) begin
         mem_ref[i] = $urandom;
         mem_slv[i] = mem_ref[i];
      end
      mem_ref[2] = 32'h0000000A;
      mem_slv[2] = 32'h0000000A;

      areset = 1'b1;
      repeat (2) @(negedge aclk);
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("reset_valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_rsp_resp", 32'(rsp_resp), 32'd0);
      chk("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
      areset = 1'b0;
      @(negedge aclk);
      chk("first_cmd_ready", 32'(cmd_ready), 32'd1);

      // zero-wait write, delayed-ARREADY read, split AW/W write
      run_txn(1, 5'h04, 32'h00000019, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      run_txn(0, 5'h08, 32'h0, 4'h0, 0, 0, 0, 3, 0, 2'b00, 0, 0);
      run_txn(1, 5'h0C, 32'hCAFEF00D, 4'hF, 3, 0, 0, 0, 0, 2'b00, 0, 0);
      // ARREADY never: abort after TO cycles
      run_txn(0, 5'h10, 32'h0, 4'h0, 0, 0, 0, NEVER, 0, 2'b00, 0, 0);
      // response held off by rsp_ready
      run_txn(0, 5'h04, 32'h0, 4'h0, 0, 0, 0, 1, 1, 2'b00, 5, 0);
      // completion exactly in the timeout cycle, then one cycle too late
      run_txn(0, 5'h08, 32'h0, 4'h0, 0, 0, 0, 3, 3, 2'b00, 0, 0);
      run_txn(1, 5'h14, 32'h12345678, 4'h5, 3, 3, 3, 0, 0, 2'b00, 0, 0);
      run_txn(1, 5'h18, 32'h9ABCDEF0, 4'hA, 3, 3, 4, 0, 0, 2'b00, 0, 0);
      run_txn(0, 5'h0C, 32'h0, 4'h0, 0, 0, 0, 3, 4, 2'b00, 0, 0);
      // AW never accepted while W completes
      run_txn(1, 5'h1C, 32'h0BADBEEF, 4'hF, NEVER, 0, 0, 0, 0, 2'b00, 0, 0);
      // slave error codes pass through
      run_txn(1, 5'h00, 32'hA5A5A5A5, 4'h3, 1, 2, 1, 0, 0, 2'b10, 0, 0);
      run_txn(0, 5'h14, 32'h0, 4'h0, 0, 0, 0, 2, 2, 2'b11, 1, 0);
      // reset pulse during WRESP
      run_txn(1, 5'h08, 32'h5555AAAA, 4'hC, 0, 0, 3, 0, 0, 2'b00, 0, 2);

      for (int t = 0; t < 40; t++) begin
         a    = int'($urandom_range(0, 7));
         aw_d = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
         w_d  = int'($urandom_range(0, 3));
         b_d  = int'($urandom_range(0, 4));
         ar_d = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
         r_d  = int'($urandom_range(0, 4));
         run_txn(1'($urandom), 5'(a * 4), $urandom, 4'($urandom), aw_d, w_d, b_d,
                 ar_d, r_d, 2'($urandom), int'($urandom_range(0, 3)), 0);
      end

      // read every register back through a zero-wait slave
      for (int i = 0; i < 8; i++)
         run_txn(0, 5'(i * 4), 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
